// File: rtl/m4_mem_cycle_sched_if.sv
// Bus bundle between the M4 SRAM cycle scheduler and its requesters.
// The master side holds the three requesters (write acquisition, RS-232C
// readout, display scan); the slave side is the scheduler, which drives the
// SRAM control/address lines and the per-reader capture strobes.
interface m4_mem_cycle_sched_if #(
    parameter int AW = 19
);
    // write requester (acquisition)
    logic          wr_req;
    logic [AW-1:0] wr_ad;
    logic          wr_bank1;
    // read requester 0 (RS-232C readout)
    logic          rd0_req;
    logic [AW-1:0] rd0_ad;
    logic          rd0_bank1;
    // read requester 1 (display scan)
    logic          rd1_req;
    logic [AW-1:0] rd1_ad;
    logic          rd1_bank1;
    // scheduler outputs
    logic          cycle_stp;
    logic          m4_cmd_cycle;
    logic [2:0]    gnt;
    logic [AW-1:0] mem_ad;
    logic          mem_bank1;
    logic          mem_oe;
    logic          mem_we;
    logic          rd0_ce;
    logic          rd1_ce;

    modport master (
        output wr_req, wr_ad, wr_bank1,
        output rd0_req, rd0_ad, rd0_bank1,
        output rd1_req, rd1_ad, rd1_bank1,
        input  cycle_stp, m4_cmd_cycle, gnt, mem_ad, mem_bank1,
        input  mem_oe, mem_we, rd0_ce, rd1_ce
    );

    modport slave (
        input  wr_req, wr_ad, wr_bank1,
        input  rd0_req, rd0_ad, rd0_bank1,
        input  rd1_req, rd1_ad, rd1_bank1,
        output cycle_stp, m4_cmd_cycle, gnt, mem_ad, mem_bank1,
        output mem_oe, mem_we, rd0_ce, rd1_ce
    );
endinterface

// File: rtl/m4_mem_cycle_sched.sv
// M4 waveform SRAM cycle scheduler.
// A free-running phase counter cuts time into fixed CYC_LEN-clock memory
// cycles. On the last phase of each cycle the next owner is chosen: the
// write requester has priority but is capped at WR_MAX back-to-back grants
// while a read waits; the two readers share the remaining cycles
// round-robin. Address/bank/owner are held for the whole cycle, and every
// SRAM strobe is a registered decode of (owner, phase) so that an
// asynchronous reset kills any strobe in the same clock.
module m4_mem_cycle_sched #(
    parameter int CYC_LEN = 8,   // clocks per memory cycle, >= 5
    parameter int CE_POS  = 5,   // read capture phase, 2..CYC_LEN-2
    parameter int WR_MAX  = 4,   // write grant cap while a read is pending, >= 1
    parameter int AW      = 19   // SRAM word address width
) (
    input  logic                 clk,
    input  logic                 rstn,
    m4_mem_cycle_sched_if.slave  bus
);

    localparam int PH_W  = (CYC_LEN > 1) ? $clog2(CYC_LEN) : 1;
    localparam int CNT_W = $clog2(WR_MAX + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CYC_LEN - 1);
    localparam logic [PH_W-1:0]  PH_OE_LO  = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_OE_HI  = PH_W'(CYC_LEN - 2);
    localparam logic [PH_W-1:0]  PH_WE_LO  = PH_W'(2);
    localparam logic [PH_W-1:0]  PH_WE_HI  = PH_W'(CYC_LEN - 3);
    localparam logic [PH_W-1:0]  PH_CE     = PH_W'(CE_POS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WR_MAX);

    // gnt bit positions: {rd1, rd0, wr}
    localparam int G_WR = 0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PH_W-1:0]  ph_reg,        ph_next;
    logic [2:0]       gnt_reg,       gnt_next;
    logic [AW-1:0]    mem_ad_reg,    mem_ad_next;
    logic             mem_bank1_reg, mem_bank1_next;
    logic             rr_reg,        rr_next;       // 0 = rd0 next in a tie
    logic [CNT_W-1:0] wr_cnt_reg,    wr_cnt_next;

    logic             cycle_stp_reg, cycle_stp_next;
    logic             cmd_cycle_reg, cmd_cycle_next;
    logic             mem_oe_reg,    mem_oe_next;
    logic             mem_we_reg,    mem_we_next;
    logic [1:0]       rd_ce_reg,     rd_ce_next;

    // ------------------------------------------------------------------
    // Read requester views, indexed by reader number
    // ------------------------------------------------------------------
    logic [1:0]       rd_req_vec;
    logic [1:0]       rd_bank_vec;
    logic [AW-1:0]    rd_ad_arr [2];
    logic             rd_pending;
    logic             rd_sel;
    logic             cyc_end;
    logic             owner_rd;

    assign rd_req_vec  = {bus.rd1_req,   bus.rd0_req};
    assign rd_bank_vec = {bus.rd1_bank1, bus.rd0_bank1};
    assign rd_ad_arr[0] = bus.rd0_ad;
    assign rd_ad_arr[1] = bus.rd1_ad;

    assign rd_pending = |rd_req_vec;
    assign cyc_end    = (ph_reg == PH_LAST);
    assign owner_rd   = gnt_reg[1] | gnt_reg[2];

    // Tie goes to the round-robin pointer; otherwise the lone requester.
    assign rd_sel = (&rd_req_vec) ? rr_reg : rd_req_vec[1];

    // Next phase: free-running wrap counter, never stalls.
    always_comb begin
        ph_next = ph_reg + 1'b1;
        if (ph_reg == PH_LAST) begin
            ph_next = '0;
        end
    end

    // Next owner/address/counters: only evaluated at the end of a cycle.
    always_comb begin
        gnt_next       = gnt_reg;
        mem_ad_next    = mem_ad_reg;
        mem_bank1_next = mem_bank1_reg;
        rr_next        = rr_reg;
        wr_cnt_next    = wr_cnt_reg;
        if (cyc_end) begin
            if (bus.wr_req && ((wr_cnt_reg < CNT_MAX) || !rd_pending)) begin
                gnt_next       = 3'b001;
                mem_ad_next    = bus.wr_ad;
                mem_bank1_next = bus.wr_bank1;
                if (wr_cnt_reg < CNT_MAX) begin
                    wr_cnt_next = wr_cnt_reg + 1'b1;
                end
            end else if (rd_pending) begin
                gnt_next       = {rd_sel, ~rd_sel, 1'b0};
                mem_ad_next    = rd_ad_arr[rd_sel];
                mem_bank1_next = rd_bank_vec[rd_sel];
                wr_cnt_next    = '0;
                if (&rd_req_vec) begin
                    rr_next = ~rr_reg;
                end
            end else begin
                // Idle cycle: address/bank keep their last value.
                gnt_next    = 3'b000;
                wr_cnt_next = '0;
            end
        end
    end

    // Strobe decode for the phase about to start. At phase 0 the owner
    // register is still the old one, but no strobe is active at phase 0.
    always_comb begin
        cycle_stp_next = (ph_next == PH_LAST);
        cmd_cycle_next = ~bus.wr_req | (wr_cnt_reg == CNT_MAX);
        mem_oe_next    = owner_rd && (ph_next >= PH_OE_LO) && (ph_next <= PH_OE_HI);
        mem_we_next    = gnt_reg[G_WR] && (ph_next >= PH_WE_LO) && (ph_next <= PH_WE_HI);
    end

    // One capture strobe per reader, fired only to the cycle owner.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_ce
            assign rd_ce_next[gi] = gnt_reg[gi + 1] && (ph_next == PH_CE);
        end
    endgenerate

    // Phase counter and registered strobes; reset clears them immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph_reg        <= '0;
            cycle_stp_reg <= 1'b0;
            cmd_cycle_reg <= 1'b0;
            mem_oe_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            rd_ce_reg     <= 2'b00;
        end else begin
            ph_reg        <= ph_next;
            cycle_stp_reg <= cycle_stp_next;
            cmd_cycle_reg <= cmd_cycle_next;
            mem_oe_reg    <= mem_oe_next;
            mem_we_reg    <= mem_we_next;
            rd_ce_reg     <= rd_ce_next;
        end
    end

    // Arbitration state: owner, held address/bank, round-robin and write cap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_reg       <= 3'b000;
            mem_ad_reg    <= '0;
            mem_bank1_reg <= 1'b0;
            rr_reg        <= 1'b0;
            wr_cnt_reg    <= '0;
        end else begin
            gnt_reg       <= gnt_next;
            mem_ad_reg    <= mem_ad_next;
            mem_bank1_reg <= mem_bank1_next;
            rr_reg        <= rr_next;
            wr_cnt_reg    <= wr_cnt_next;
        end
    end

    assign bus.cycle_stp    = cycle_stp_reg;
    assign bus.m4_cmd_cycle = cmd_cycle_reg;
    assign bus.gnt          = gnt_reg;
    assign bus.mem_ad       = mem_ad_reg;
    assign bus.mem_bank1    = mem_bank1_reg;
    assign bus.mem_oe       = mem_oe_reg;
    assign bus.mem_we       = mem_we_reg;
    assign bus.rd0_ce       = rd_ce_reg[0];
    assign bus.rd1_ce       = rd_ce_reg[1];

endmodule

// File: tb/tb_m4_mem_cycle_sched.sv
// Bench for the M4 SRAM cycle scheduler (default parameters: 8-clock cycle,
// capture at phase 5, write cap 4). Request vectors are applied on the last
// phase of a cycle; the expected owner/address for the following cycle is
// queued and a monitor checks every phase of that cycle against it.
module tb_m4_mem_cycle_sched;

    localparam int AW = 19;

    localparam logic [AW-1:0] WR_AD  = 19'h00011;
    localparam logic [AW-1:0] RD0_AD = 19'h1234A;
    localparam logic [AW-1:0] RD1_AD = 19'h7FFFF;

    typedef struct {
        logic          wr;
        logic          rd0;
        logic          rd1;
        logic [2:0]    gnt;
        logic [AW-1:0] ad;
        logic          bank;
        logic          cmd;
    } vec_t;

    typedef struct {
        logic [2:0]    gnt;
        logic [AW-1:0] ad;
        logic          bank;
        logic          cmd;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   tb_ph = 0;
    int   n_run = 0;
    int   n_fail = 0;

    exp_t exp_q[$];
    exp_t cur;
    logic cur_valid = 1'b0;
    vec_t vecs [21];

    m4_mem_cycle_sched_if #(.AW(AW)) bus ();

    m4_mem_cycle_sched #(
        .CYC_LEN (8),
        .CE_POS  (5),
        .WR_MAX  (4),
        .AW      (AW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference phase: 0 after reset, +1 per clock, wraps after 7.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) tb_ph <= 0;
        else       tb_ph <= (tb_ph == 7) ? 0 : tb_ph + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t ph=%0d)", nm, act, req, $time, tb_ph);
        end
    endtask

    // Advance at least one clock, stop at the falling edge where phase == p.
    task automatic wait_ph(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_ph != p && n < 20);
        if (tb_ph != p) chk("wait_ph_timeout", 32'(tb_ph), 32'(p));
    endtask

    task automatic drive(input logic wr, input logic rd0, input logic rd1);
        bus.wr_req  = wr;
        bus.rd0_req = rd0;
        bus.rd1_req = rd1;
    endtask

    // Monitor: pop the expectation at phase 0, check every phase of that cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            cur_valid = 1'b0;
        end else begin
            if (tb_ph == 0) begin
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                end else begin
                    cur_valid = 1'b0;
                end
            end
            chk("cycle_stp", 32'(bus.cycle_stp), 32'(tb_ph == 7));
            if (cur_valid) begin
                chk("gnt",       32'(bus.gnt),       32'(cur.gnt));
                chk("mem_ad",    32'(bus.mem_ad),    32'(cur.ad));
                chk("mem_bank1", 32'(bus.mem_bank1), 32'(cur.bank));
                chk("mem_oe", 32'(bus.mem_oe),
                    32'((cur.gnt[1] | cur.gnt[2]) && tb_ph >= 1 && tb_ph <= 6));
                chk("mem_we", 32'(bus.mem_we), 32'(cur.gnt[0] && tb_ph >= 2 && tb_ph <= 5));
                chk("rd0_ce", 32'(bus.rd0_ce), 32'(cur.gnt[1] && tb_ph == 5));
                chk("rd1_ce", 32'(bus.rd1_ce), 32'(cur.gnt[2] && tb_ph == 5));
                if (tb_ph == 4) chk("m4_cmd_cycle", 32'(bus.m4_cmd_cycle), 32'(cur.cmd));
                if (tb_ph == 7)
                    $display("[TB] cycle done: gnt=%b mem_ad=%05h bank=%b", bus.gnt, bus.mem_ad, bus.mem_bank1);
            end
        end
    end

    initial begin
        // {wr, rd0, rd1, exp gnt, exp mem_ad, exp bank, exp m4_cmd_cycle}
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'b010, RD0_AD, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'b010, RD0_AD, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 3'b100, RD1_AD, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 3'b010, RD0_AD, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 3'b100, RD1_AD, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'b000, RD1_AD, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b001, WR_AD,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b001, WR_AD,  1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b001, WR_AD,  1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b001, WR_AD,  1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b010, RD0_AD, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b001, WR_AD,  1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b001, WR_AD,  1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 3'b001, WR_AD,  1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 3'b001, WR_AD,  1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 3'b001, WR_AD,  1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 3'b010, RD0_AD, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 3'b001, WR_AD,  1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 3'b100, RD1_AD, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 3'b100, RD1_AD, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 3'b000, RD1_AD, 1'b1, 1'b1};

        rstn = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        bus.wr_ad = WR_AD;   bus.wr_bank1 = 1'b1;
        bus.rd0_ad = RD0_AD; bus.rd0_bank1 = 1'b0;
        bus.rd1_ad = RD1_AD; bus.rd1_bank1 = 1'b1;
        #3 rstn = 1'b0;

        // Reset held, requests toggling: every output stays 0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("rst_gnt",       32'(bus.gnt),          32'd0);
            chk("rst_mem_ad",    32'(bus.mem_ad),       32'd0);
            chk("rst_mem_bank1", 32'(bus.mem_bank1),    32'd0);
            chk("rst_oe_we",     32'({bus.mem_oe, bus.mem_we}), 32'd0);
            chk("rst_ce",        32'({bus.rd1_ce, bus.rd0_ce}), 32'd0);
            chk("rst_cycle_stp", 32'(bus.cycle_stp),    32'd0);
            chk("rst_cmd_cycle", 32'(bus.m4_cmd_cycle), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rstn = 1'b1;

        // cycle_stp first after 7 clocks, then every 8; bus idle meanwhile.
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("stp_after_reset", 32'(bus.cycle_stp), 32'(k == 7 || k == 15));
            chk("idle_gnt",        32'(bus.gnt),       32'd0);
        end

        // Table: drive on the last phase, expect the result in the next cycle.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].wr, vecs[i].rd0, vecs[i].rd1);
            exp_q.push_back('{vecs[i].gnt, vecs[i].ad, vecs[i].bank, vecs[i].cmd});
            $display("[TB] vec %0d: wr=%b rd0=%b rd1=%b -> gnt=%b ad=%05h",
                     i, vecs[i].wr, vecs[i].rd0, vecs[i].rd1, vecs[i].gnt, vecs[i].ad);
            wait_ph(7);
        end

        // Reset at phase 3 of a write cycle: WE drops in the same clock.
        bus.wr_ad = 19'h00055; bus.wr_bank1 = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        exp_q.push_back('{3'b001, 19'h00055, 1'b0, 1'b0});
        wait_ph(3);
        chk("we_before_reset", 32'(bus.mem_we), 32'd1);
        #1 rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("we_at_reset",     32'(bus.mem_we), 32'd0);
        chk("gnt_at_reset",    32'(bus.gnt),    32'd0);
        chk("mem_ad_at_reset", 32'(bus.mem_ad), 32'd0);
        $display("[TB] reset asserted mid write cycle");
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("restart_stp", 32'(bus.cycle_stp), 32'(k == 7));
            chk("restart_gnt", 32'(bus.gnt),       32'((k == 8) ? 3'b001 : 3'b000));
            chk("restart_we",  32'(bus.mem_we),    32'd0);
        end

        // rd0 drops its request mid-cycle: the grant and its strobe survive.
        wait_ph(7);
        bus.rd0_ad = 19'h0BEEF; bus.rd0_bank1 = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        exp_q.push_back('{3'b010, 19'h0BEEF, 1'b1, 1'b1});
        wait_ph(2);
        bus.rd0_req = 1'b0;
        wait_ph(5);
        chk("rd0_ce_after_drop", 32'(bus.rd0_ce), 32'd1);
        chk("gnt_after_drop",    32'(bus.gnt),    32'b010);
        wait_ph(7);
        wait_ph(7);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Hard bound on the whole run.
    initial begin
        #50000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
